arbitro_escrita_br: RTL
=======================

Name: arbitro_escrita_br

Overview:
- Shares the single write port of the register bank between two writeback requesters: requester 0 is the ALU result and requester 1 is the memory load.
- Each requester has a one-entry holding buffer with a valid/ack handshake.
- A round-robin arbiter drains the buffers onto the bank's Hab_Escrita / Sel_SC / dado_escrita inputs, one write per cycle.
- A per-register pending-write mask is exported so decode logic can stall reads of registers with writes in flight.

Parameters:
- bits_palavra, 16, data word width.
- end_registros, 2, register address width.
- num_registros, 4, number of registers; equals 2**end_registros.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous reset, active-low: asserted when 0, clears all state immediately.
- req0  input  1  requester 0 presents a write this cycle.
- sel0  input  end_registros  requester 0 destination register.
- dado0  input  bits_palavra  requester 0 write data.
- ack0  output  1  requester 0 buffer can accept; a transfer happens on a rising edge with req0=1 and ack0=1.
- req1, sel1, dado1, ack1  same as above, for requester 1.
- Hab_Escrita  output  1  write enable to the register bank.
- Sel_SC  output  end_registros  write address to the register bank.
- dado_escrita  output  bits_palavra  write data to the register bank.
- pendente  output  num_registros  bit r=1 while any write to register r is buffered or being issued.
- ocupado  output  1  any buffer full or Hab_Escrita=1.

Behaviour:
- Reset (reset=0, asynchronous):
  - both buffers empty; Hab_Escrita=0, Sel_SC=0, dado_escrita=0.
  - round-robin pointer set so requester 0 wins the first tie.
  - resulting outputs: ack0=ack1=1, pendente=0, ocupado=0.
  - Reset mid-operation discards buffered and issuing writes; no bank write occurs on that edge.
- Handshake:
  - ackN = !cheioN, decoded from registered state only, never from reqN.
  - On an edge with reqN & ackN, the buffer captures selN/dadoN and cheioN becomes 1.
  - reqN with ackN=0 is ignored; the requester must hold its data and retry.
  - A buffer drains on the edge at which it is granted. It can re-accept no earlier than the following edge, so sustained throughput is one write per 2 cycles per requester.
- Arbitration (evaluated each cycle from registered state):
  - One buffer full: that buffer is granted.
  - Both full: grant the requester not granted most recently; the pointer updates only on a grant.
- Issue stage (registered outputs):
  - On a grant edge: Hab_Escrita<=1, Sel_SC<=buffer sel, dado_escrita<=buffer data.
  - On a non-grant edge: Hab_Escrita<=0; Sel_SC and dado_escrita hold their last values.
- Latency: capture at edge N, grant/issue at edge N+1 (if uncontended), bank write at edge N+2. A contended request loses exactly one extra cycle.
- Same-destination conflict: both buffers targeting one register are written in grant order, and the later write wins. No merging or dropping.
- pendente = decode(sel0)&cheio0 | decode(sel1)&cheio1 | decode(Sel_SC)&Hab_Escrita. It is combinational from registers only. Bits clear the cycle after the bank write edge.
- No arithmetic on data; widths pass through unchanged. sel values are always in range because num_registros = 2**end_registros.

Test Plan:
- Reset check: reset=0 mid-run with both buffers full → immediately Hab_Escrita=0, ack0=ack1=1, pendente=4'b0000; the bank holds its old contents after release.
- Single write: req0=1, sel0=2, dado0=16'h00A5 at edge 1 → ack0=0 and pendente=4'b0100 after edge 1; Hab_Escrita=1, Sel_SC=2, dado_escrita=16'h00A5 after edge 2; pendente=0 and ack0=1 after edge 3.
- Simultaneous requests from reset: req0 (sel 1, 16'h1111) and req1 (sel 3, 16'h3333) at the same edge → issue order 16'h1111 then 16'h3333 on consecutive cycles; pendente=4'b1010 then 4'b1000 then 0.
- Fairness: both requesters streaming continuously for 20 cycles → grants strictly alternate 0,1,0,1; no requester waits more than 1 cycle after capture beyond the base latency.
- Same-register race: req0 (sel 0, 16'h0001) and req1 (sel 0, 16'h0002) captured together, with pointer favouring 1 → register 0 ends at 16'h0001; pendente[0] stays 1 until the second write is issued.
- Backpressure: hold req1=1 with changing dado1 while ack1=0 → only the value present on the edge where ack1=1 is written.

Source files
------------

// File: rtl/arbitro_escrita_br.sv
// Purpose: shares the register bank write port between ALU writeback (req 0) and load writeback (req 1).
// Latency: capture at edge N, issue at edge N+1 when uncontended, bank write at edge N+2; a lost tie adds one cycle.
// Backpressure: ackN = !cheioN from registered state only; a requester seeing ackN=0 holds its data and retries.
module arbitro_escrita_br #(
  parameter int bits_palavra  = 16,
  parameter int end_registros = 2,
  parameter int num_registros = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req0,
  input  logic [end_registros-1:0] sel0,
  input  logic [bits_palavra-1:0]  dado0,
  output logic                     ack0,
  input  logic                     req1,
  input  logic [end_registros-1:0] sel1,
  input  logic [bits_palavra-1:0]  dado1,
  output logic                     ack1,
  output logic                     Hab_Escrita,
  output logic [end_registros-1:0] Sel_SC,
  output logic [bits_palavra-1:0]  dado_escrita,
  output logic [num_registros-1:0] pendente,
  output logic                     ocupado
);

  // One-entry holding buffers, one per requester.
  logic                     cheio0;
  logic [end_registros-1:0] buf_sel0;
  logic [bits_palavra-1:0]  buf_dado0;
  logic                     cheio1;
  logic [end_registros-1:0] buf_sel1;
  logic [bits_palavra-1:0]  buf_dado1;

  // Round-robin pointer: 1 means requester 1 wins the next tie.
  logic prio1;

  // Grants are decoded from registered state only, so the ack path never
  // depends on the incoming request and cannot form a combinational loop.
  logic grant0;
  logic grant1;

  assign grant0 = cheio0 && (!cheio1 || !prio1);
  assign grant1 = cheio1 && (!cheio0 ||  prio1);

  // A full buffer refuses new data; it reopens only on the edge after it drains.
  assign ack0 = !cheio0;
  assign ack1 = !cheio1;

  assign ocupado = cheio0 || cheio1 || Hab_Escrita;

  // Buffer 0: drain on grant, otherwise capture on a completed handshake.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cheio0    <= 1'b0;
      buf_sel0  <= '0;
      buf_dado0 <= '0;
    end else if (grant0) begin
      cheio0 <= 1'b0;
    end else if (req0 && ack0) begin
      cheio0    <= 1'b1;
      buf_sel0  <= sel0;
      buf_dado0 <= dado0;
    end
  end

  // Buffer 1: same policy as buffer 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cheio1    <= 1'b0;
      buf_sel1  <= '0;
      buf_dado1 <= '0;
    end else if (grant1) begin
      cheio1 <= 1'b0;
    end else if (req1 && ack1) begin
      cheio1    <= 1'b1;
      buf_sel1  <= sel1;
      buf_dado1 <= dado1;
    end
  end

  // Pointer moves away from whoever was just granted; idle cycles leave it alone.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prio1 <= 1'b0;
    end else if (grant0) begin
      prio1 <= 1'b1;
    end else if (grant1) begin
      prio1 <= 1'b0;
    end
  end

  // Issue stage: registered bank controls; address/data hold when idle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      Hab_Escrita  <= 1'b0;
      Sel_SC       <= '0;
      dado_escrita <= '0;
    end else if (grant0) begin
      Hab_Escrita  <= 1'b1;
      Sel_SC       <= buf_sel0;
      dado_escrita <= buf_dado0;
    end else if (grant1) begin
      Hab_Escrita  <= 1'b1;
      Sel_SC       <= buf_sel1;
      dado_escrita <= buf_dado1;
    end else begin
      Hab_Escrita <= 1'b0;
    end
  end

  // Pending mask: a register is busy while buffered or being issued to the bank.
  always_comb begin
    pendente = '0;
    for (int r = 0; r < num_registros; r++) begin
      pendente[r] = (cheio0      && (buf_sel0 == end_registros'(r))) ||
                    (cheio1      && (buf_sel1 == end_registros'(r))) ||
                    (Hab_Escrita && (Sel_SC   == end_registros'(r)));
    end
  end

endmodule
